// File: rtl/apu_wb_scheduler.sv
// Writeback slot scheduler for the shared APU: reserves the single result slot at
// issue time from fixed class latencies and replays each reservation as a tagged strobe.
module apu_wb_scheduler #(
  parameter int TAG_W        = 5,
  parameter int MAX_LAT      = 8,
  parameter int LAT_ADDSUB   = 1,
  parameter int LAT_MULT     = 1,
  parameter int LAT_CAST     = 1,
  parameter int LAT_MAC      = 2,
  parameter int LAT_DIV      = 4,
  parameter int LAT_SQRT     = 5,
  parameter int LAT_DSP_MULT = 1,
  parameter bit IN_ORDER     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         req_i,
  input  logic [2:0]                   op_class_i,
  input  logic [TAG_W-1:0]             tag_i,
  output logic                         gnt_o,
  output logic                         illegal_o,
  output logic                         wb_valid_o,
  output logic [TAG_W-1:0]             wb_tag_o,
  output logic [$clog2(MAX_LAT+1)-1:0] inflight_o,
  output logic                         busy_o
);

  localparam int CNT_W = $clog2(MAX_LAT+1);

  typedef enum logic [2:0] {
    OP_ADDSUB   = 3'd0,
    OP_MULT     = 3'd1,
    OP_CAST     = 3'd2,
    OP_MAC      = 3'd3,
    OP_DIV      = 3'd4,
    OP_SQRT     = 3'd5,
    OP_DSP_MULT = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_class_e;

  // Entry k holds the writeback due k cycles from now; entry 0 is being emitted.
  logic [MAX_LAT-1:0] p_v, p_v_nxt;
  logic [TAG_W-1:0]   p_tag     [MAX_LAT];
  logic [TAG_W-1:0]   p_tag_nxt [MAX_LAT];
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   lat;
  logic               legal;
  logic               slot_taken;
  logic               later_pending;
  logic               issue;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lat   = '0;
    legal = 1'b1;
    case (op_class_e'(op_class_i))
      OP_ADDSUB:   lat = CNT_W'(LAT_ADDSUB);
      OP_MULT:     lat = CNT_W'(LAT_MULT);
      OP_CAST:     lat = CNT_W'(LAT_CAST);
      OP_MAC:      lat = CNT_W'(LAT_MAC);
      OP_DIV:      lat = CNT_W'(LAT_DIV);
      OP_SQRT:     lat = CNT_W'(LAT_SQRT);
      OP_DSP_MULT: lat = CNT_W'(LAT_DSP_MULT);
      default:     legal = 1'b0;
    endcase
  end

  // After this edge's shift, entry L moves into L-1; a MAX_LAT latency never collides.
  always_comb begin
    slot_taken    = 1'b0;
    later_pending = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (p_v[k] && k == int'(lat)) slot_taken = 1'b1;
      if (p_v[k] && k >= int'(lat)) later_pending = 1'b1;
    end
  end

  assign gnt_o     = req_i & legal & ~slot_taken & (~IN_ORDER | ~later_pending)
                   & ~flush_i & ~rst;
  assign illegal_o = req_i & ~legal;
  assign issue     = gnt_o;

  always_comb begin
    p_v_nxt = {1'b0, p_v[MAX_LAT-1:1]};
    for (int i = 0; i < MAX_LAT - 1; i++) p_tag_nxt[i] = p_tag[i+1];
    p_tag_nxt[MAX_LAT-1] = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (issue && i == int'(lat) - 1) begin
        p_v_nxt[i]   = 1'b1;
        p_tag_nxt[i] = tag_i;
      end
    end
    if (flush_i) p_v_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_v      <= '0;
      inflight <= '0;
      // NOTE: the tag pipe is small flops, not RAM, so it is reset to give a clean wb_tag_o.
      for (int i = 0; i < MAX_LAT; i++) p_tag[i] <= '0;
    end else begin
      p_v <= p_v_nxt;
      for (int i = 0; i < MAX_LAT; i++) p_tag[i] <= p_tag_nxt[i];
      if (flush_i)              inflight <= '0;
      else if (issue && !p_v[0]) inflight <= inflight + 1'b1;
      else if (!issue && p_v[0]) inflight <= inflight - 1'b1;
    end
  end

  assign wb_valid_o = p_v[0];
  assign wb_tag_o   = p_tag[0];
  assign inflight_o = inflight;
  assign busy_o     = (inflight != '0);

endmodule
